qdiv_arb: RTL
=============

QDIV_ARB -- requirements
Module: qdiv_arb

Interface
REQ-001 The module SHALL have parameter Q, default 15, meaning fractional bits of the signed-magnitude fixed-point format.
REQ-002 The module SHALL have parameter N, default 32, meaning total word width, with bit N-1 as the sign.
REQ-003 The module SHALL have parameter NREQ, default 4, meaning number of requesters.
REQ-004 The module SHALL have parameter TMO, default 64, meaning the WAIT-state timeout in cycles.
REQ-005 The module SHALL use one clock; reset is asynchronous and active-low, with clock port clk and reset port rst_n.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 req  in  NREQ  per-requester request, level, held until granted.
REQ-009 req_dividend  in  NREQ*N  packed dividends, slice i belongs to requester i.
REQ-010 req_divisor  in  NREQ*N  packed divisors, slice i belongs to requester i.
REQ-011 gnt  out  NREQ  one-hot, one-cycle pulse; operands of the granted requester are captured in that cycle.
REQ-012 rsp_valid  out  1  response valid, held until accepted.
REQ-013 rsp_ready  in  1  response accept.
REQ-014 rsp_id  out  clog2(NREQ)  index of the requester that owns the response.
REQ-015 rsp_quotient  out  N  result word.
REQ-016 rsp_dbz  out  1  divide-by-zero flag.
REQ-017 rsp_tmo  out  1  divider-timeout flag.
REQ-018 div_dividend  out  N  operand to the shared divider, registered.
REQ-019 div_divisor  out  N  operand to the shared divider, registered.
REQ-020 div_start  out  1  divider start.
REQ-021 div_quotient  in  N  divider result.
REQ-022 div_done  in  1  divider completion.

Function
REQ-023 The FSM SHALL have exactly the states IDLE, LAUNCH, WAIT and RESP, encoded in a single state register.
REQ-024 In IDLE with any req bit set, the block SHALL grant the first set bit searching upward from ptr with wrap, pulse gnt for 1 cycle, capture operands into div_dividend/div_divisor, and capture the index into rsp_id.
REQ-025 At the grant, ptr SHALL become (granted index+1) mod NREQ; ptr SHALL not change when no grant is issued.
REQ-026 When the captured divisor has magnitude bits [N-2:0] all zero, the block SHALL go IDLE->RESP with rsp_dbz=1 and rsp_quotient = {sign(dividend) XOR sign(divisor), all ones}, and SHALL NOT assert div_start.
REQ-027 Otherwise the block SHALL go IDLE->LAUNCH.
REQ-028 In LAUNCH, div_start SHALL be 1 for exactly one cycle, the timer SHALL be cleared, and the next state SHALL be WAIT.
REQ-029 div_start SHALL be 0 in every state other than LAUNCH.
REQ-030 In WAIT, div_done SHALL be ignored in the first WAIT cycle, which guards against a stale done from the prior operation.
REQ-031 From the second WAIT cycle, div_done=1 SHALL capture div_quotient into rsp_quotient, set rsp_dbz=0 and rsp_tmo=0, and move to RESP.
REQ-032 When the timer reaches TMO-1 without done, the block SHALL move to RESP with rsp_tmo=1 and rsp_quotient=0.
REQ-033 If done and timeout occur in the same cycle, done SHALL win.
REQ-034 In RESP, rsp_valid SHALL be 1, and rsp_id, rsp_quotient, rsp_dbz and rsp_tmo SHALL be stable until rsp_valid && rsp_ready, after which the next state SHALL be IDLE.
REQ-035 No grant SHALL be issued while the FSM is outside IDLE.
REQ-036 Back-to-back throughput: the earliest next gnt SHALL be the cycle after the rsp_valid && rsp_ready handshake.
REQ-037 Nominal latency from gnt to rsp_valid SHALL be 1 (LAUNCH) + divider latency (N+Q cycles for the standard qdiv) + 1; a divide-by-zero SHALL take 1 cycle.
REQ-038 req deasserting while not granted SHALL be legal and SHALL have no effect.
REQ-039 Operand changes after the grant SHALL NOT affect the operation in flight.

Reset
REQ-040 While rst_n=0, state=IDLE, ptr=0, and gnt, rsp_valid, rsp_id, rsp_quotient, rsp_dbz, rsp_tmo, div_dividend, div_divisor, div_start and the timer SHALL all be 0, applied immediately and independent of clk.
REQ-041 A reset during LAUNCH, WAIT or RESP SHALL abandon the operation with no response; after release, the first grant SHALL use ptr=0.

Verification
REQ-042 Scenario: req[0] with dividend 0x80104000 (-32.5) and divisor 0x00012000 (2.25) -> gnt[0] pulse, one div_start pulse, rsp_id=0, rsp_quotient=0x800738E3 (-14.4444), dbz=0, tmo=0.
REQ-043 Scenario: req=4'b1111 held with rsp_ready=1 -> grants in order 0,1,2,3,0, with exactly one gnt bit per operation.
REQ-044 Scenario: divisor 0x80000000 (-0) and dividend 0x00010000 -> rsp_dbz=1, rsp_quotient=0xFFFFFFFF, rsp_valid one cycle after gnt, and div_start never high.
REQ-045 Scenario: divider stub with div_done stuck at 0 -> rsp_tmo=1 and rsp_quotient=0 exactly TMO cycles after entering WAIT.
REQ-046 Scenario: rsp_ready=0 for 10 cycles in RESP while req[2]=1 -> rsp_valid and all response fields stay stable and gnt stays 0; after rsp_ready=1, gnt[2] follows on the next cycle.
REQ-047 Scenario: rst_n pulled low mid-WAIT -> all outputs 0 within the same cycle and no rsp_valid; after release with req=4'b0110, the first grant is gnt[1].

Source files
------------

// File: rtl/qdiv_arb.sv
// rtl/qdiv_arb.sv - round-robin arbiter sharing one signed-magnitude fixed-point divider
module qdiv_arb #(
  parameter int Q    = 15,
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int TMO  = 64,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int TW  = (TMO > 1) ? $clog2(TMO) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*N-1:0]  req_dividend,
  input  logic [NREQ*N-1:0]  req_divisor,
  output logic [NREQ-1:0]    gnt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IW-1:0]      rsp_id,
  output logic [N-1:0]       rsp_quotient,
  output logic               rsp_dbz,
  output logic               rsp_tmo,
  output logic [N-1:0]       div_dividend,
  output logic [N-1:0]       div_divisor,
  output logic               div_start,
  input  logic [N-1:0]       div_quotient,
  input  logic               div_done
);

  // The fraction must leave room for at least the sign bit in the word.
  if (Q < 0 || Q >= N - 1) begin : g_bad_q
    $error("qdiv_arb: Q must lie in [0, N-2]");
  end
  if (TMO < 2) begin : g_bad_tmo
    $error("qdiv_arb: TMO must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic [N-1:0]    rsp_quotient_q, rsp_quotient_d;
  logic            rsp_dbz_q, rsp_dbz_d;
  logic            rsp_tmo_q, rsp_tmo_d;
  logic [N-1:0]    div_dividend_q, div_dividend_d;
  logic [N-1:0]    div_divisor_q, div_divisor_d;
  logic [NREQ-1:0] gnt_raw;

  logic [N-1:0]    dvd_a [NREQ];
  logic [N-1:0]    dvs_a [NREQ];
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [N-1:0]    sel_dvd;
  logic [N-1:0]    sel_dvs;
  int              cand;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign dvd_a[g] = req_dividend[g*N +: N];
    assign dvs_a[g] = req_divisor[g*N +: N];
  end

  // Rotating priority search: first request at or above ptr_q, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!sel_found && req[IW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(cand);
      end
    end
  end

  assign sel_dvd = dvd_a[sel_idx];
  assign sel_dvs = dvs_a[sel_idx];

  // Next-state and datapath: grant/capture in IDLE, timed wait for the divider, hold response.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    timer_d        = timer_q;
    rsp_id_d       = rsp_id_q;
    rsp_quotient_d = rsp_quotient_q;
    rsp_dbz_d      = rsp_dbz_q;
    rsp_tmo_d      = rsp_tmo_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    gnt_raw        = '0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          gnt_raw[sel_idx] = 1'b1;
          ptr_d            = IW'((int'(sel_idx) + 1) % NREQ);
          rsp_id_d         = sel_idx;
          div_dividend_d   = sel_dvd;
          div_divisor_d    = sel_dvs;
          // A zero magnitude (either sign) never reaches the divider.
          if (sel_dvs[N-2:0] == '0) begin
            state_d        = S_RESP;
            rsp_dbz_d      = 1'b1;
            rsp_tmo_d      = 1'b0;
            rsp_quotient_d = {sel_dvd[N-1] ^ sel_dvs[N-1], {(N-1){1'b1}}};
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // timer_q == 0 marks the first WAIT cycle, where done may still be left over.
        if (timer_q != '0 && div_done) begin
          rsp_quotient_d = div_quotient;
          rsp_dbz_d      = 1'b0;
          rsp_tmo_d      = 1'b0;
          state_d        = S_RESP;
        end else if (timer_q == TW'(TMO - 1)) begin
          rsp_quotient_d = '0;
          rsp_dbz_d      = 1'b0;
          rsp_tmo_d      = 1'b1;
          state_d        = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured operands/results; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      timer_q        <= '0;
      rsp_id_q       <= '0;
      rsp_quotient_q <= '0;
      rsp_dbz_q      <= 1'b0;
      rsp_tmo_q      <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      timer_q        <= timer_d;
      rsp_id_q       <= rsp_id_d;
      rsp_quotient_q <= rsp_quotient_d;
      rsp_dbz_q      <= rsp_dbz_d;
      rsp_tmo_q      <= rsp_tmo_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
    end
  end

  // gnt is combinational from req, so it is also forced low while reset is held.
  assign gnt          = gnt_raw & {NREQ{rst_n}};
  assign div_start    = (state_q == S_LAUNCH);
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_dbz      = rsp_dbz_q;
  assign rsp_tmo      = rsp_tmo_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor  = div_divisor_q;

endmodule
